// File: rtl/operand_loader.sv
// operand_loader: gathers one x/dx/a/u operand frame from a valid/ready nibble
// stream into a private shadow buffer and checks that the frame is legal.
// It then replays the frame onto the solver datapath `in` bus. Each operand
// gets its own one-hot load strobe, and `start` pulses after the last one.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      operand nibble stream (order x, dx, a, u)
//   abort                          synchronous frame cancel, highest priority
//   dp_busy                        solver busy; holds a checked frame in WAIT
//   out_data                       datapath `in` bus, 0 when no strobe is high
//   load_x/load_dx/load_a/load_u   one-cycle load strobes
//   start                          one-cycle pulse after load_u
//   frame_err                      one-cycle pulse on a rejected frame
//   frame_cnt                      frames issued, wraps modulo 2^CNT_W
module operand_loader #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  input  logic              dp_busy,
  output logic [DATA_W-1:0] out_data,
  output logic              load_x,
  output logic              load_dx,
  output logic              load_a,
  output logic              load_u,
  output logic              start,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned NUM_OPS = 4;
  localparam int unsigned IDX_W   = 2;

  // Shadow slot indices, in stream order.
  localparam logic [IDX_W-1:0] SLOT_X  = IDX_W'(0);
  localparam logic [IDX_W-1:0] SLOT_DX = IDX_W'(1);
  localparam logic [IDX_W-1:0] SLOT_A  = IDX_W'(2);
  localparam logic [IDX_W-1:0] SLOT_U  = IDX_W'(3);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_WAIT,
    S_ISSUE,
    S_START
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_OPS-1:0][DATA_W-1:0]   shadow_q, shadow_d;
  logic [NUM_OPS-1:0]               load_q, load_d;
  logic [DATA_W-1:0]                out_q, out_d;
  logic                             start_q, start_d;
  logic                             err_q, err_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             run_q;
  logic                             accept;
  logic                             illegal;

  // Keeps in_ready low while reset is asserted and for the cycle in which it is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign in_ready = run_q && (state_q == S_COLLECT) && !abort;
  assign accept   = in_valid && in_ready;
  assign illegal  = (shadow_q[SLOT_DX] == '0) || (shadow_q[SLOT_X] >= shadow_q[SLOT_A]);

  // Next-state logic. The registered outputs are decoded from the next state,
  // so each strobe lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    load_d   = '0;
    out_d    = '0;
    start_d  = 1'b0;

    if (abort) begin
      state_d  = S_COLLECT;
      idx_d    = '0;
      shadow_d = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            shadow_d[idx_q] = in_data;
            idx_d           = idx_q + IDX_W'(1);
            if (idx_q == SLOT_U) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          idx_d = '0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = S_COLLECT;
          end else if (dp_busy) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_WAIT: begin
          if (!dp_busy) begin
            state_d = S_ISSUE;
            idx_d   = '0;
          end
        end
        S_ISSUE: begin
          // dp_busy is intentionally ignored once replay has started.
          if (idx_q == SLOT_U) begin
            state_d = S_START;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_START: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_COLLECT;
          idx_d   = '0;
        end
        default: begin
          state_d = S_COLLECT;
          idx_d   = '0;
        end
      endcase
    end

    if (state_d == S_ISSUE) begin
      load_d[idx_d] = 1'b1;
      out_d         = shadow_d[idx_d];
    end
    start_d = (state_d == S_START);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_COLLECT;
      idx_q    <= '0;
      shadow_q <= '0;
      load_q   <= '0;
      out_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      load_q   <= load_d;
      out_q    <= out_d;
      start_q  <= start_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign load_x    = load_q[SLOT_X];
  assign load_dx   = load_q[SLOT_DX];
  assign load_a    = load_q[SLOT_A];
  assign load_u    = load_q[SLOT_U];
  assign out_data  = out_q;
  assign start     = start_q;
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: scoreboard of expected strobes plus
// a frame table, and hand sequences for timing, busy, abort, reset and wrap.
module tb_operand_loader;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic              dp_busy;
  logic [DATA_W-1:0] out_data;
  logic              load_x, load_dx, load_a, load_u;
  logic              start, frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  always #5 clk = ~clk;

  operand_loader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .dp_busy(dp_busy),
    .out_data(out_data),
    .load_x(load_x), .load_dx(load_dx), .load_a(load_a), .load_u(load_u),
    .start(start), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;
  int start_seen = 0;
  int err_seen = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  logic       prev_u = 1'b0;
  logic [CNT_W-1:0] exp_cnt;
  logic [3:0] loads;

  assign loads = {load_u, load_a, load_dx, load_x};

  typedef struct {
    logic [3:0] x, dx, a, u;
    bit         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] l);
    case (l)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  // Strobe scoreboard: every strobe must match the next expected {slot, data}.
  always @(negedge clk) begin
    if (loads != 4'b0000) begin
      check("strobe_onehot", 32'($countones(loads)), 32'd1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL strobe_unexpected: loads=%b data=%0d, none expected at %0t", loads, out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_slot_data", 32'({enc(loads), out_data}), 32'(mon_e));
      end
    end
    if (start) begin
      check("start_after_load_u", 32'(prev_u), 32'd1);
      start_seen++;
    end
    if (frame_err) err_seen++;
    prev_u = load_u;
  end

  task automatic push(input logic [3:0] x, dx, a, u, input int n);
    logic [3:0] v[4];
    v[0] = x; v[1] = dx; v[2] = a; v[3] = u;
    for (int i = 0; i < n; i++) exp_q.push_back({2'(i), v[i]});
  endtask

  // Starts and ends at 1 ns after a rising edge.
  task automatic send(input logic [3:0] d, input bit gaps, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL handshake_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic send_frame(input logic [3:0] x, dx, a, u, input bit gaps, output int waited);
    logic [3:0] v[4];
    int w;
    v[0] = x; v[1] = dx; v[2] = a; v[3] = u;
    waited = 0;
    for (int i = 0; i < 4; i++) begin
      send(v[i], gaps, w);
      waited += w;
    end
  endtask

  // Entered in the CHECK cycle; returns 1 ns after the edge that follows the pulse.
  task automatic wait_done(input bit legal);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (legal ? start : frame_err) seen = 1'b1;
    end
    check(legal ? "start_seen" : "frame_err_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[8];
    logic [3:0] e_ld[7];
    logic [3:0] e_out[7];
    logic       e_st[7];
    logic       e_rdy[7];
    logic       e_err[3];
    logic       e_rdy2[3];
    int         w, err0, st0;
    logic [3:0] rx, rdx, ra, ru;

    tbl[0] = '{x: 4'd0,  dx: 4'd15, a: 4'd15, u: 4'd15, exp_err: 1'b0};
    tbl[1] = '{x: 4'd9,  dx: 4'd1,  a: 4'd9,  u: 4'd0,  exp_err: 1'b1};
    tbl[2] = '{x: 4'd14, dx: 4'd1,  a: 4'd15, u: 4'd0,  exp_err: 1'b0};
    tbl[3] = '{x: 4'd15, dx: 4'd1,  a: 4'd15, u: 4'd7,  exp_err: 1'b1};
    tbl[4] = '{x: 4'd3,  dx: 4'd1,  a: 4'd2,  u: 4'd4,  exp_err: 1'b1};
    tbl[5] = '{x: 4'd0,  dx: 4'd1,  a: 4'd1,  u: 4'd0,  exp_err: 1'b0};
    tbl[6] = '{x: 4'd0,  dx: 4'd0,  a: 4'd1,  u: 4'd5,  exp_err: 1'b1};
    tbl[7] = '{x: 4'd7,  dx: 4'd8,  a: 4'd8,  u: 4'd10, exp_err: 1'b0};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    dp_busy  = 1'b0;
    exp_cnt  = '0;

    // Reset values.
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_outputs", 32'({loads, out_data, start, frame_err}), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Legal frame x=1 dx=2 a=9 u=3, exact cycle timing T+1..T+7.
    push(4'd1, 4'd2, 4'd9, 4'd3, 4);
    send_frame(4'd1, 4'd2, 4'd9, 4'd3, 1'b0, w);
    check("ready_4_back_to_back", 32'(w), 32'd0);
    e_ld  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    e_out = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd3, 4'd0, 4'd0};
    e_st  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("f1_loads_c%0d", i + 1), 32'(loads), 32'(e_ld[i]));
      check($sformatf("f1_out_c%0d", i + 1), 32'(out_data), 32'(e_out[i]));
      check($sformatf("f1_start_c%0d", i + 1), 32'(start), 32'(e_st[i]));
      check($sformatf("f1_ready_c%0d", i + 1), 32'(in_ready), 32'(e_rdy[i]));
      if (i == 5) check("f1_cnt_during_start", 32'(frame_cnt), 32'd0);
      if (i < 6) begin
        @(posedge clk); #1;
      end
    end
    exp_cnt = exp_cnt + 8'd1;
    check("f1_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    @(posedge clk); #1;

    // dx == 0 frame: frame_err in T+2, in_ready back in T+2, no strobes.
    send_frame(4'd5, 4'd0, 4'd9, 4'd1, 1'b0, w);
    e_err  = '{1'b0, 1'b1, 1'b0};
    e_rdy2 = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("err_pulse_c%0d", i + 1), 32'(frame_err), 32'(e_err[i]));
      check($sformatf("err_ready_c%0d", i + 1), 32'(in_ready), 32'(e_rdy2[i]));
      check($sformatf("err_loads_c%0d", i + 1), 32'(loads), 32'd0);
      @(posedge clk); #1;
    end
    check("err_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Frame table.
    for (int k = 0; k < 8; k++) begin
      err0 = err_seen;
      st0  = start_seen;
      if (!tbl[k].exp_err) push(tbl[k].x, tbl[k].dx, tbl[k].a, tbl[k].u, 4);
      send_frame(tbl[k].x, tbl[k].dx, tbl[k].a, tbl[k].u, 1'b1, w);
      wait_done(!tbl[k].exp_err);
      if (!tbl[k].exp_err) exp_cnt = exp_cnt + 8'd1;
      check($sformatf("tbl%0d_err", k), 32'(err_seen - err0), 32'(tbl[k].exp_err));
      check($sformatf("tbl%0d_start", k), 32'(start_seen - st0), 32'(!tbl[k].exp_err));
      check($sformatf("tbl%0d_cnt", k), 32'(frame_cnt), 32'(exp_cnt));
    end

    // dp_busy high through T+6: no strobes, load_x one cycle after it falls.
    dp_busy = 1'b1;
    push(4'd2, 4'd4, 4'd11, 4'd5, 4);
    send_frame(4'd2, 4'd4, 4'd11, 4'd5, 1'b0, w);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("busy_no_strobe_c%0d", i), 32'({loads, start}), 32'd0);
      @(posedge clk); #1;
    end
    dp_busy = 1'b0;
    @(negedge clk);
    check("busy_fall_cycle", 32'(loads), 32'd0);
    @(posedge clk); #1;
    dp_busy = 1'b1;
    @(negedge clk);
    check("busy_load_x", 32'({loads, out_data}), 32'({4'b0001, 4'd2}));
    wait_done(1'b1);
    dp_busy = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("busy_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Abort during load_dx: nothing more from this frame.
    err0 = err_seen;
    push(4'd1, 4'd3, 4'd4, 4'd2, 2);
    send_frame(4'd1, 4'd3, 4'd4, 4'd2, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_load_dx", 32'(loads), 32'b0010);
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_c%0d", i), 32'({loads, start, frame_err}), 32'd0);
      if (i == 0) check("abort_ready_back", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    check("abort_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("abort_no_err", 32'(err_seen - err0), 32'd0);
    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

    // Abort mid-COLLECT with a nibble offered: nibble refused, partial frame dropped.
    send(4'd7, 1'b0, w);
    send(4'd7, 1'b0, w);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd15;
    @(negedge clk);
    check("abort_collect_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    push(4'd2, 4'd3, 4'd8, 4'd6, 4);
    send_frame(4'd2, 4'd3, 4'd8, 4'd6, 1'b0, w);
    wait_done(1'b1);
    exp_cnt = exp_cnt + 8'd1;
    check("after_abort_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Asynchronous reset mid-COLLECT.
    send(4'd3, 1'b0, w);
    send(4'd1, 1'b0, w);
    reset_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(in_ready), 32'd0);
    check("async_reset_outputs", 32'({loads, out_data, start, frame_err}), 32'd0);
    check("async_reset_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_cnt = '0;
    @(posedge clk); #1;

    // 256 random legal frames with random valid gaps; counter wraps to 0.
    for (int k = 0; k < 256; k++) begin
      rx  = 4'($urandom_range(0, 14));
      ra  = 4'($urandom_range(32'(rx) + 1, 15));
      rdx = 4'($urandom_range(1, 15));
      ru  = 4'($urandom);
      push(rx, rdx, ra, ru, 4);
      send_frame(rx, rdx, ra, ru, 1'b1, w);
      wait_done(1'b1);
      exp_cnt = exp_cnt + 8'd1;
      check($sformatf("wrap_cnt_%0d", k), 32'(frame_cnt), 32'(exp_cnt));
    end
    check("wrap_final_zero", 32'(frame_cnt), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
